exec_ctrl: RTL and testbench
============================

EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 The block SHALL have parameter M_REG, default 8'h26, giving the fixed memory address written by MOVM.
REQ-002 The block SHALL have parameter AW, default 8, giving the address and PC width.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  launches execution when sampled high in IDLE or HALTED.
REQ-006 start_addr  input  8  first instruction address, sampled with start.
REQ-007 mem_rdata  input  8  combinational read data for mem_addr, valid in the same cycle.
REQ-008 mem_addr  output  8  memory address.
REQ-009 mem_we  output  1  memory write strobe; the memory writes on the next clk edge.
REQ-010 wsel  output  2  datapath write-data mux: 00 A, 01 B, 10 T.
REQ-011 ld_a, ld_b, ld_t  output  1 each  one-cycle load strobes for datapath registers A, B and T.
REQ-012 a_src  output  1  A load source: 0 mem_rdata, 1 ALU.
REQ-013 alu_sub  output  1  ALU mode: 0 A+B, 1 A-B (mod 256).
REQ-014 busy, done, err  output  1 each  status flags.
REQ-015 pc  output  8  current program counter.

Function
REQ-016 Every instruction SHALL be two bytes: an opcode byte, where only bits [3:0] are decoded, followed by an operand address byte OPR.
REQ-017 Opcodes SHALL be: NOP 0, MOVA 1 (A<=mem[OPR]), MOVB 2 (B<=mem[OPR]), ADD 3 (A<=A+B), SUB 6 (A<=A-B), HALT 8, MOVAM 9 (mem[OPR]<=A), MOVBM A (mem[OPR]<=B), MOVM C (mem[M_REG]<=mem[OPR]).
REQ-018 States SHALL be IDLE, FETCH, OPER, EXEC, EXEC2 and HALTED.
REQ-019 IDLE: on start=1, pc<=start_addr, then go to FETCH.
REQ-020 FETCH: mem_addr=pc; IR<=mem_rdata[3:0]; pc<=pc+1; then go to OPER.
REQ-021 OPER: mem_addr=pc; OPR<=mem_rdata; pc<=pc+1; then go to EXEC.
REQ-022 EXEC for MOVA/MOVB: mem_addr=OPR with ld_a (a_src=0) or ld_b asserted for one cycle, then go to FETCH.
REQ-023 EXEC for ADD/SUB: ld_a=1, a_src=1, alu_sub=(IR==6), then go to FETCH.
REQ-024 EXEC for MOVAM/MOVBM: mem_addr=OPR, mem_we=1, wsel=00 or 01, then go to FETCH.
REQ-025 MOVM: EXEC drives mem_addr=OPR with ld_t=1, then goes to EXEC2; EXEC2 drives mem_addr=M_REG, mem_we=1, wsel=10, then goes to FETCH.
REQ-026 NOP: EXEC asserts no strobes, then goes to FETCH.
REQ-027 HALT: EXEC goes to HALTED; done=1 while in HALTED.
REQ-028 An undefined opcode SHALL execute as NOP, set err sticky until the next accepted start or reset, and continue execution.
REQ-029 The instruction latency SHALL be 3 cycles (FETCH to next FETCH), and 4 cycles for MOVM.
REQ-030 pc SHALL wrap from 8'hFF to 8'h00 with no flag.
REQ-031 In HALTED, start=1 SHALL clear done and err, load pc<=start_addr and go to FETCH.
REQ-032 start SHALL be ignored in FETCH, OPER, EXEC and EXEC2.
REQ-033 busy SHALL be 1 in FETCH, OPER, EXEC and EXEC2, and 0 otherwise.
REQ-034 mem_we, ld_a, ld_b and ld_t SHALL never be asserted outside EXEC and EXEC2, and at most one of them SHALL be asserted per cycle.
REQ-035 In any state without a memory access, mem_addr SHALL equal pc.

Reset
REQ-036 While rst=0, the block SHALL immediately enter IDLE with pc=0, IR=0, OPR=0, all strobes 0, wsel=00, a_src=0, alu_sub=0, and busy=done=err=0.
REQ-037 Reset asserted mid-instruction SHALL abort that instruction with no mem_we pulse generated in or after the reset cycle.
REQ-038 Once rst returns high, the block SHALL wait in IDLE for start.

Verification
REQ-039 Program at 0x10: 01 20, 02 21, 03 00, 09 22, 08 00, with mem[20]=5 and mem[21]=7; start_addr=0x10 -> model mem[22]=0x0C, done=1 after 15 cycles, pc=0x1A.
REQ-040 Program 01 30, 02 31, 06 00, 08 00 with mem[30]=3 and mem[31]=5 -> A=0xFE, with alu_sub=1 for exactly one cycle.
REQ-041 Program 0C 40, 08 00 with mem[40]=0x5A -> mem[26]=0x5A, ld_t then mem_we in consecutive cycles, MOVM taking 4 cycles.
REQ-042 start_addr=0xFE holding 0A 10, then 08 00 at address 00 -> mem[10]=B, pc wraps to 00, done=1.
REQ-043 Opcode 0x5 followed by HALT -> err=1 and done=1; a restart with start clears both flags.
REQ-044 rst pulsed low during EXEC of MOVAM -> no write to the target address, all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/exec_ctrl_if.sv
// exec_ctrl_if -- memory bus and datapath control bundle for exec_ctrl.
//
// Signals:
//   mem_addr  [AW-1:0]  memory address
//   mem_we              write strobe, memory writes on the next clk edge
//   mem_rdata [7:0]     combinational read data for mem_addr
//   wsel      [1:0]     write-data mux: 00 A, 01 B, 10 T
//   ld_a/ld_b/ld_t      one-cycle load strobes for datapath registers
//   a_src               A load source: 0 mem_rdata, 1 ALU
//   alu_sub             ALU mode: 0 A+B, 1 A-B
//
// master: the controller (drives address and strobes, reads mem_rdata)
// slave : the memory/datapath side
interface exec_ctrl_if #(
  parameter int AW = 8
);
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_rdata;
  logic [1:0]    wsel;
  logic          ld_a;
  logic          ld_b;
  logic          ld_t;
  logic          a_src;
  logic          alu_sub;

  modport master (
    output mem_addr, mem_we, wsel, ld_a, ld_b, ld_t, a_src, alu_sub,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_we, wsel, ld_a, ld_b, ld_t, a_src, alu_sub,
    output mem_rdata
  );
endinterface

// File: rtl/exec_ctrl.sv
// exec_ctrl -- sequencer for a tiny two-byte-instruction machine.
// Fetches opcode and operand bytes from memory, then drives load/write
// strobes for an external datapath (registers A, B, T and an add/sub ALU).
//
// Ports:
//   clk         clock, all state changes on its rising edge
//   rst         asynchronous active-low reset
//   start       launch execution (honoured only in IDLE or HALTED)
//   start_addr  first instruction address, sampled with start
//   bus         exec_ctrl_if master: memory address/strobe/read data and
//               datapath controls
//   busy        high in FETCH, OPER, EXEC, EXEC2
//   done        high while HALTED
//   err         sticky: an undefined opcode was executed since last start
//   pc          current program counter
module exec_ctrl #(
  parameter int            AW    = 8,
  parameter logic [AW-1:0] M_REG = AW'(8'h26)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  exec_ctrl_if.master   bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] pc
);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_MOVA  = 4'h1;
  localparam logic [3:0] OP_MOVB  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h8;
  localparam logic [3:0] OP_MOVAM = 4'h9;
  localparam logic [3:0] OP_MOVBM = 4'hA;
  localparam logic [3:0] OP_MOVM  = 4'hC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_OPER,
    S_EXEC,
    S_EXEC2,
    S_HALTED
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] pc_reg, pc_next;
  logic [3:0]    ir_reg, ir_next;
  logic [7:0]    opr_reg, opr_next;
  logic          err_reg, err_next;

  // Output-comb intermediates, forwarded to the interface below.
  logic [AW-1:0] mem_addr_c;
  logic          mem_we_c;
  logic [1:0]    wsel_c;
  logic          ld_a_c, ld_b_c, ld_t_c, a_src_c, alu_sub_c;

  // State register. The asynchronous reset forces IDLE immediately, and
  // since every strobe is decoded from the state, any in-flight write is
  // cancelled in the same cycle reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
      opr_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      opr_reg   <= opr_next;
      err_reg   <= err_next;
    end
  end

  // Next-state and register update logic.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    opr_next   = opr_reg;
    err_next   = err_reg;
    case (state_reg)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_next = S_FETCH;
          pc_next    = start_addr;
          err_next   = 1'b0;
        end
      end
      S_FETCH: begin
        ir_next    = bus.mem_rdata[3:0];
        pc_next    = pc_reg + AW'(1);
        state_next = S_OPER;
      end
      S_OPER: begin
        opr_next   = bus.mem_rdata;
        pc_next    = pc_reg + AW'(1);
        state_next = S_EXEC;
      end
      S_EXEC: begin
        case (ir_reg)
          OP_HALT: state_next = S_HALTED;
          OP_MOVM: state_next = S_EXEC2;
          OP_NOP, OP_MOVA, OP_MOVB, OP_ADD, OP_SUB, OP_MOVAM, OP_MOVBM:
            state_next = S_FETCH;
          default: begin
            // Undefined opcode: behaves as NOP but leaves a sticky flag.
            err_next   = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_EXEC2: state_next = S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode. mem_addr follows pc unless this cycle accesses OPR or
  // M_REG, so the opcode/operand reads in FETCH/OPER need no special case.
  always_comb begin
    mem_addr_c = pc_reg;
    mem_we_c   = 1'b0;
    wsel_c     = 2'b00;
    ld_a_c     = 1'b0;
    ld_b_c     = 1'b0;
    ld_t_c     = 1'b0;
    a_src_c    = 1'b0;
    alu_sub_c  = 1'b0;
    case (state_reg)
      S_EXEC: begin
        case (ir_reg)
          OP_MOVA: begin
            mem_addr_c = AW'(opr_reg);
            ld_a_c     = 1'b1;
          end
          OP_MOVB: begin
            mem_addr_c = AW'(opr_reg);
            ld_b_c     = 1'b1;
          end
          OP_ADD: begin
            ld_a_c  = 1'b1;
            a_src_c = 1'b1;
          end
          OP_SUB: begin
            ld_a_c    = 1'b1;
            a_src_c   = 1'b1;
            alu_sub_c = 1'b1;
          end
          OP_MOVAM: begin
            mem_addr_c = AW'(opr_reg);
            mem_we_c   = 1'b1;
            wsel_c     = 2'b00;
          end
          OP_MOVBM: begin
            mem_addr_c = AW'(opr_reg);
            mem_we_c   = 1'b1;
            wsel_c     = 2'b01;
          end
          OP_MOVM: begin
            // First half of the memory-to-memory move: capture into T.
            mem_addr_c = AW'(opr_reg);
            ld_t_c     = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        mem_addr_c = M_REG;
        mem_we_c   = 1'b1;
        wsel_c     = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr = mem_addr_c;
  assign bus.mem_we   = mem_we_c;
  assign bus.wsel     = wsel_c;
  assign bus.ld_a     = ld_a_c;
  assign bus.ld_b     = ld_b_c;
  assign bus.ld_t     = ld_t_c;
  assign bus.a_src    = a_src_c;
  assign bus.alu_sub  = alu_sub_c;

  assign busy = (state_reg == S_FETCH) || (state_reg == S_OPER) ||
                (state_reg == S_EXEC)  || (state_reg == S_EXEC2);
  assign done = (state_reg == S_HALTED);
  assign err  = err_reg;
  assign pc   = pc_reg;

endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl -- scoreboard bench for exec_ctrl.
// The bench owns a memory and the A/B/T datapath. An ISA-level model
// interprets each program from its own copy of memory and queues the
// expected strobe events and the expected completion; a negedge monitor
// pops and compares whenever the DUT asserts a strobe or raises done.
module tb_exec_ctrl;
  localparam int         AW    = 8;
  localparam logic [7:0] M_REG = 8'h26;

  localparam logic [7:0] C_LDA = 8'h80;
  localparam logic [7:0] C_ADD = 8'hC0;
  localparam logic [7:0] C_SUB = 8'hE0;
  localparam logic [7:0] C_LDB = 8'h10;
  localparam logic [7:0] C_LDT = 8'h08;
  localparam logic [7:0] C_WEA = 8'h04;
  localparam logic [7:0] C_WEB = 8'h05;
  localparam logic [7:0] C_WET = 8'h06;

  typedef struct {
    logic [7:0] code;
    logic [7:0] addr;
    bit         chk_addr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] pc;
    bit         err;
    logic [7:0] a;
    int         lat;
  } fin_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] start_addr = 8'h00;
  logic       busy, done, err;
  logic [7:0] pc;

  exec_ctrl_if #(.AW(AW)) bus ();

  exec_ctrl #(.AW(AW), .M_REG(M_REG)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  // ---------------- environment: memory + datapath ----------------
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] a_q = 8'h00, b_q = 8'h00, t_q = 8'h00;
  logic [7:0] alu_y, wdata;
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = 8'h00, pl_data = 8'h00;
  int         cyc = 0;

  assign bus.mem_rdata = mem[bus.mem_addr];
  assign alu_y = bus.alu_sub ? (a_q - b_q) : (a_q + b_q);
  always_comb begin
    case (bus.wsel)
      2'b01:   wdata = b_q;
      2'b10:   wdata = t_q;
      default: wdata = a_q;
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= wdata;
    if (bus.ld_a) a_q <= bus.a_src ? alu_y : bus.mem_rdata;
    if (bus.ld_b) b_q <= bus.mem_rdata;
    if (bus.ld_t) t_q <= bus.mem_rdata;
  end

  // ---------------- scoreboard ----------------
  ev_t  exp_q[$];
  fin_t fin_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   st_cyc = 0;
  int   sub_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic       done_q = 1'b0;
  logic       m_any, m_acc, m_ok;
  logic [7:0] m_code, m_data;
  ev_t        m_e;
  fin_t       m_f;

  always @(negedge clk) begin
    if (rst) begin
      m_any  = bus.ld_a | bus.ld_b | bus.ld_t | bus.mem_we;
      m_acc  = (bus.ld_a & ~bus.a_src) | bus.ld_b | bus.ld_t | bus.mem_we;
      m_code = {bus.ld_a, bus.a_src, bus.alu_sub, bus.ld_b, bus.ld_t, bus.mem_we, bus.wsel};
      m_data = bus.ld_a ? (bus.a_src ? alu_y : bus.mem_rdata)
                        : (bus.mem_we ? wdata : bus.mem_rdata);
      m_ok = ($countones({bus.ld_a, bus.ld_b, bus.ld_t, bus.mem_we}) <= 1) &&
             (busy || !m_any) && (m_acc || bus.mem_addr == pc) &&
             (!(bus.a_src | bus.alu_sub) || bus.ld_a) &&
             (bus.wsel == 2'b00 || bus.mem_we) && !(busy && done);
      n_cmp++;
      if (!m_ok) begin
        n_bad++;
        $display("FAIL invariant: got code=%0h busy=%0b done=%0b addr=%0h pc=%0h, required legal strobes/addr",
                 m_code, busy, done, bus.mem_addr, pc);
      end
      if (bus.alu_sub) sub_cnt++;
      if (m_any) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL event_unexpected: got code=%0h addr=%0h, required no strobe", m_code, bus.mem_addr);
        end else begin
          m_e = exp_q.pop_front();
          chk("ev_code", {24'd0, m_code}, {24'd0, m_e.code});
          if (m_e.chk_addr) chk("ev_addr", {24'd0, bus.mem_addr}, {24'd0, m_e.addr});
          chk("ev_data", {24'd0, m_data}, {24'd0, m_e.data});
        end
      end
      if (done && !done_q) begin
        if (fin_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done_unexpected: got done=1 pc=%0h, required no completion", pc);
        end else begin
          m_f = fin_q.pop_front();
          chk("fin_pc", {24'd0, pc}, {24'd0, m_f.pc});
          chk("fin_err", {31'd0, err}, {31'd0, m_f.err});
          chk("fin_a", {24'd0, a_q}, {24'd0, m_f.a});
          chk("fin_latency", cyc - st_cyc, m_f.lat);
          chk("fin_busy", {31'd0, busy}, 32'd0);
        end
      end
    end
    done_q = done;
  end

  // ---------------- reference model (ISA level) ----------------
  logic [7:0] model_mem [256] = '{default: 8'h00};
  logic [7:0] model_a = 8'h00, model_b = 8'h00, model_t = 8'h00;

  task automatic push_ev(input logic [7:0] code, input logic [7:0] addr, input bit ca, input logic [7:0] data);
    exp_q.push_back('{code: code, addr: addr, chk_addr: ca, data: data});
  endtask

  task automatic model_run(input logic [7:0] sa, output int lat);
    logic [7:0] p;
    logic [3:0] op;
    logic [7:0] opr;
    int         c;
    bit         e;
    p = sa; c = 0; e = 0; lat = 0;
    for (int n = 0; n < 300; n++) begin
      op  = model_mem[p][3:0];
      opr = model_mem[p + 8'd1];
      p   = p + 8'd2;
      c   = c + 3;
      case (op)
        4'h0: ;
        4'h1: begin model_a = model_mem[opr]; push_ev(C_LDA, opr, 1, model_a); end
        4'h2: begin model_b = model_mem[opr]; push_ev(C_LDB, opr, 1, model_b); end
        4'h3: begin model_a = model_a + model_b; push_ev(C_ADD, 8'h00, 0, model_a); end
        4'h6: begin model_a = model_a - model_b; push_ev(C_SUB, 8'h00, 0, model_a); end
        4'h8: begin
          fin_q.push_back('{pc: p, err: e, a: model_a, lat: c});
          lat = c;
          return;
        end
        4'h9: begin model_mem[opr] = model_a; push_ev(C_WEA, opr, 1, model_a); end
        4'hA: begin model_mem[opr] = model_b; push_ev(C_WEB, opr, 1, model_b); end
        4'hC: begin
          model_t = model_mem[opr];
          push_ev(C_LDT, opr, 1, model_t);
          model_mem[M_REG] = model_t;
          push_ev(C_WET, M_REG, 1, model_t);
          c = c + 1;
        end
        default: e = 1;
      endcase
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    model_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic run(input logic [7:0] sa, input bit noise);
    int c;
    int d;
    model_run(sa, c);
    @(negedge clk);
    start = 1'b1; start_addr = sa;
    @(posedge clk); #1;
    start = 1'b0; start_addr = 8'($urandom); st_cyc = cyc;
    chk("start_clears", {30'd0, done, err}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < c + 20; i++) begin
      @(negedge clk); #1;
      if (fin_q.size() == 0) break;
      d = cyc - st_cyc;
      start = (noise && d < c - 1) ? 1'($urandom) : 1'b0;
      start_addr = 8'($urandom);
    end
    start = 1'b0;
    chk("completion_seen", fin_q.size(), 32'd0);
    chk("events_drained", exp_q.size(), 32'd0);
    fin_q.delete();
    exp_q.delete();
    $display("run sa=%02h latency=%0d pc=%02h A=%02h err=%0b", sa, c, pc, a_q, err);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_status"}, {29'd0, busy, done, err}, 32'd0);
    chk({pfx, "_pc"}, {24'd0, pc}, 32'd0);
    chk({pfx, "_addr"}, {24'd0, bus.mem_addr}, 32'd0);
    chk({pfx, "_ctrl"}, {24'd0, bus.ld_a, bus.ld_b, bus.ld_t, bus.mem_we, bus.a_src,
                         bus.alu_sub, bus.wsel}, 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s0;
    logic [3:0] op;
    logic [7:0] pa;

    repeat (3) @(posedge clk);
    #1 chk_reset("reset");
    @(negedge clk) rst = 1'b1;

    for (int a = 8'h80; a < 256; a++) poke(8'(a), 8'($urandom));

    // Sum program: A=5, B=7, A=A+B, mem[22]=A
    poke(8'h20, 8'h05); poke(8'h21, 8'h07);
    poke(8'h10, 8'h01); poke(8'h11, 8'h20); poke(8'h12, 8'h02); poke(8'h13, 8'h21);
    poke(8'h14, 8'h03); poke(8'h15, 8'h00); poke(8'h16, 8'h09); poke(8'h17, 8'h22);
    poke(8'h18, 8'h08); poke(8'h19, 8'h00);
    run(8'h10, 0);
    chk("sum_mem22", {24'd0, mem[8'h22]}, 32'h0C);
    chk("sum_pc", {24'd0, pc}, 32'h1A);

    // Subtract program: 3 - 5 = 0xFE, alu_sub high exactly one cycle
    poke(8'h30, 8'h03); poke(8'h31, 8'h05);
    poke(8'h00, 8'h01); poke(8'h01, 8'h30); poke(8'h02, 8'h02); poke(8'h03, 8'h31);
    poke(8'h04, 8'h06); poke(8'h05, 8'h00); poke(8'h06, 8'h08); poke(8'h07, 8'h00);
    s0 = sub_cnt;
    run(8'h00, 0);
    chk("sub_a", {24'd0, a_q}, 32'hFE);
    chk("sub_cycles", sub_cnt - s0, 32'd1);

    // MOVM: mem[M_REG] <= mem[40]
    poke(8'h40, 8'h5A);
    poke(8'h00, 8'h0C); poke(8'h01, 8'h40); poke(8'h02, 8'h08); poke(8'h03, 8'h00);
    run(8'h00, 0);
    chk("movm_mem26", {24'd0, mem[8'h26]}, 32'h5A);

    // PC wrap: MOVBM at FE/FF, HALT at 00
    poke(8'hFE, 8'h0A); poke(8'hFF, 8'h10); poke(8'h00, 8'h08); poke(8'h01, 8'h00);
    run(8'hFE, 0);
    chk("wrap_mem10", {24'd0, mem[8'h10]}, 32'h05);
    chk("wrap_pc", {24'd0, pc}, 32'h02);

    // Undefined opcode sets err; restart with a clean program clears it
    poke(8'h00, 8'h05); poke(8'h01, 8'h00); poke(8'h02, 8'h08); poke(8'h03, 8'h00);
    run(8'h00, 0);
    chk("undef_flags", {30'd0, done, err}, 32'd3);
    poke(8'h00, 8'h00);
    run(8'h00, 0);
    chk("restart_flags", {30'd0, done, err}, 32'd2);

    // Random programs, start toggled while busy (must be ignored)
    for (int t = 0; t < 8; t++) begin
      pa = 8'h40;
      for (int k = 0; k < 10; k++) begin
        op = 4'($urandom_range(0, 14));
        if (op >= 4'h8) op = op + 4'h1;
        poke(pa, {4'($urandom), op});
        poke(pa + 8'd1, 8'h80 | 8'($urandom_range(0, 127)));
        pa = pa + 8'd2;
      end
      poke(pa, {4'($urandom), 4'h8});
      poke(pa + 8'd1, 8'($urandom));
      run(8'h40, 1);
    end

    // Reset during EXEC of MOVAM: write must be suppressed
    poke(8'h00, 8'h01); poke(8'h01, 8'h90); poke(8'h02, 8'h09); poke(8'h03, 8'hA0);
    poke(8'h04, 8'h08); poke(8'h05, 8'h00);
    poke(8'hA0, ~model_mem[8'h90]);
    push_ev(C_LDA, 8'h90, 1, model_mem[8'h90]);
    @(negedge clk);
    start = 1'b1; start_addr = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_we) break;
      @(posedge clk); #1;
    end
    chk("abort_reached_we", {31'd0, bus.mem_we}, 32'd1);
    rst = 1'b0;
    #1 chk_reset("abort");
    @(posedge clk); #1;
    chk("abort_nowrite", {24'd0, mem[8'hA0]}, {24'd0, model_mem[8'hA0]});
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_reset("idle_wait");
    chk("abort_events", exp_q.size(), 32'd0);
    $display("reset abort mem[A0]=%02h busy=%0b", mem[8'hA0], busy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
